// File: rtl/booth_pkg.sv
// Shared command codes, FSM state type and small helpers for the booth
// multiplier sequencing controller.
package booth_pkg;

   localparam logic [2:0] CMD_NOP     = 3'b000;
   localparam logic [2:0] CMD_INIT    = 3'b001;
   localparam logic [2:0] CMD_LOAD_M  = 3'b011;
   localparam logic [2:0] CMD_LOAD_Q  = 3'b010;
   localparam logic [2:0] CMD_RUN     = 3'b100;
   localparam logic [2:0] CMD_READ_HI = 3'b101;
   localparam logic [2:0] CMD_READ_LO = 3'b110;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_LDM,
      ST_SETQ,
      ST_LDQ,
      ST_RUN,
      ST_RDHI,
      ST_RDLO,
      ST_DONE
   } state_t;

   function automatic logic [1:0] owner_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that was
// not granted last wins; a lone requester always wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = last_ptr ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencer that arbitrates two operand requesters and drives a booth
// multiplier through its command protocol, returning a 16-bit product.
//
// state | meaning
// IDLE  | waiting for an accepted request, req_ready follows the arbiter
// INIT  | multiplier cleared, M on the bus
// LDM   | multiplicand loaded from bus
// SETQ  | bus switched to Q with a NOP so the multiplier sees it settle
// LDQ   | multiplier loaded from bus
// RUN   | RUN_CYCLES iterations, paced by run_cnt down-counter
// RDHI  | high product byte read back
// RDLO  | low product byte read back
// DONE  | rsp_valid pulse to the owning requester
module booth_ctrl
   import booth_pkg::*;
#(
   parameter int unsigned RUN_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [15:0] req_m,
   input  logic [15:0] req_q,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_product,
   output logic        busy,
   output logic [7:0]  mul_inbus,
   output logic [2:0]  mul_enable,
   input  logic [7:0]  mul_outbus
);

   localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] run_cnt;
   logic             last_ptr;
   logic             owner;
   logic [7:0]       m_lat;
   logic [7:0]       q_lat;
   logic [7:0]       prod_hi;
   logic [1:0]       grant;
   logic             accept;
   logic [7:0]       m_sel;
   logic [7:0]       q_sel;

   rr_arb2 u_arb (
      .req      (req_valid),
      .last_ptr (last_ptr),
      .grant    (grant)
   );

   assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign busy      = (state != ST_IDLE);
   assign m_sel     = grant[1] ? req_m[15:8] : req_m[7:0];
   assign q_sel     = grant[1] ? req_q[15:8] : req_q[7:0];

   // Outputs are registered alongside the state, so each is loaded with
   // the value belonging to the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         run_cnt     <= '0;
         last_ptr    <= 1'b1;
         owner       <= 1'b0;
         m_lat       <= '0;
         q_lat       <= '0;
         prod_hi     <= '0;
         mul_enable  <= CMD_NOP;
         mul_inbus   <= '0;
         rsp_valid   <= '0;
         rsp_product <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               mul_enable <= CMD_NOP;
               if (accept) begin
                  m_lat      <= m_sel;
                  q_lat      <= q_sel;
                  owner      <= grant[1];
                  last_ptr   <= grant[1];
                  mul_inbus  <= m_sel;
                  mul_enable <= CMD_INIT;
                  state      <= ST_INIT;
               end
            end
            ST_INIT: begin
               mul_inbus  <= m_lat;
               mul_enable <= CMD_LOAD_M;
               state      <= ST_LDM;
            end
            ST_LDM: begin
               mul_inbus  <= q_lat;
               mul_enable <= CMD_NOP;
               state      <= ST_SETQ;
            end
            ST_SETQ: begin
               mul_inbus  <= q_lat;
               mul_enable <= CMD_LOAD_Q;
               state      <= ST_LDQ;
            end
            ST_LDQ: begin
               run_cnt    <= RUN_LOAD;
               mul_enable <= CMD_RUN;
               state      <= ST_RUN;
            end
            ST_RUN: begin
               if (run_cnt == '0) begin
                  mul_enable <= CMD_READ_HI;
                  state      <= ST_RDHI;
               end else begin
                  run_cnt <= run_cnt - 1'b1;
               end
            end
            ST_RDHI: begin
               prod_hi    <= mul_outbus;
               mul_enable <= CMD_READ_LO;
               state      <= ST_RDLO;
            end
            ST_RDLO: begin
               rsp_product <= {prod_hi, mul_outbus};
               rsp_valid   <= owner_onehot(owner);
               mul_enable  <= CMD_NOP;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               mul_enable <= CMD_NOP;
               state      <= ST_IDLE;
            end
            default: begin
               mul_enable <= CMD_NOP;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural booth multiplier, vector table and a
// scoreboard of expected responses pushed at acceptance time.
module tb_booth_ctrl;
   import booth_pkg::*;

   localparam int RUN_CYCLES = 8;
   localparam int LATENCY    = 7 + RUN_CYCLES;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_m;
   logic [15:0] req_q;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_product;
   logic        busy;
   logic [7:0]  mul_inbus;
   logic [2:0]  mul_enable;
   logic [7:0]  mul_outbus;

   booth_ctrl #(.RUN_CYCLES(RUN_CYCLES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_m       (req_m),
      .req_q       (req_q),
      .rsp_valid   (rsp_valid),
      .rsp_product (rsp_product),
      .busy        (busy),
      .mul_inbus   (mul_inbus),
      .mul_enable  (mul_enable),
      .mul_outbus  (mul_outbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
   endfunction

   // Behavioural multiplier: only yields a valid product after exactly
   // RUN_CYCLES run commands following INIT.
   logic [7:0]  bm_m;
   logic [7:0]  bm_q;
   int          bm_runs;
   logic [15:0] bm_prod;

   always @(posedge clk) begin
      case (mul_enable)
         CMD_INIT:   begin bm_m <= 8'h00; bm_q <= 8'h00; bm_runs <= 0; end
         CMD_LOAD_M: bm_m <= mul_inbus;
         CMD_LOAD_Q: bm_q <= mul_inbus;
         CMD_RUN:    bm_runs <= bm_runs + 1;
         default:    ;
      endcase
   end

   always_comb begin
      bm_prod    = (bm_runs == RUN_CYCLES) ? mul8(bm_m, bm_q) : 16'hDEAD;
      mul_outbus = 8'h00;
      if (mul_enable == CMD_READ_HI) mul_outbus = bm_prod[15:8];
      else if (mul_enable == CMD_READ_LO) mul_outbus = bm_prod[7:0];
   end

   typedef struct {
      logic        owner;
      logic [15:0] prod;
      int          t;
   } sb_t;

   typedef struct {
      logic owner;
      int   t;
   } grant_t;

   typedef struct {
      logic        owner;
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] exp;
   } vec_t;

   sb_t         sb[$];
   grant_t      glog[$];
   logic [2:0]  en_log[$];
   logic [7:0]  ib_log[$];
   vec_t        vecs[7];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [1:0]  acc_now;
   logic        rec_arm = 1'b0;
   logic        rec_en  = 1'b0;
   logic [15:0] last_prod;
   logic        last_owner;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: condition not met (t=%0t)", name, $time);
   endtask

   // Called once per cycle at the falling edge while out of reset.
   task automatic sample();
      sb_t    e;
      grant_t g;
      if (rec_en) begin
         en_log.push_back(mul_enable);
         ib_log.push_back(mul_inbus);
      end
      if (busy) chk("ready_outside_idle", {30'd0, req_ready}, 32'd0);
      acc_now = req_valid & req_ready;
      if (acc_now != 2'b00) begin
         if (acc_now == 2'b11) flag("double_grant");
         e.owner = acc_now[1];
         e.prod  = mul8(e.owner ? req_m[15:8] : req_m[7:0], e.owner ? req_q[15:8] : req_q[7:0]);
         e.t     = cyc;
         sb.push_back(e);
         g.owner = e.owner;
         g.t     = cyc;
         glog.push_back(g);
         if (rec_arm) begin
            rec_en  = 1'b1;
            rec_arm = 1'b0;
         end
      end
      if (rsp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            flag("unexpected_rsp");
         end else begin
            e = sb.pop_front();
            chk("rsp_owner", {30'd0, rsp_valid}, e.owner ? 32'd2 : 32'd1);
            chk("rsp_product", {16'd0, rsp_product}, {16'd0, e.prod});
            chk("rsp_latency", cyc - e.t, LATENCY);
            last_prod  = rsp_product;
            last_owner = rsp_valid[1];
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int n, input logic [1:0] drop, input int budget);
      int got = 0;
      for (int i = 0; i < budget && got < n; i++) begin
         @(negedge clk);
         sample();
         if (acc_now != 2'b00) got++;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~(acc_now & drop);
      end
      if (got < n) flag("accept_timeout");
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while ((sb.size() != 0 || busy) && i < budget) begin
         tick();
         i++;
      end
      if (sb.size() != 0 || busy) flag("rsp_timeout");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      req_valid = 2'b00;
      rst_n     = 1'b0;
      sb.delete();
      rec_en    = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_en[15];
      int runs;

      vecs[0] = '{1'b0, 8'h11, 8'h03, 16'h0033};
      vecs[1] = '{1'b1, 8'hFF, 8'h05, 16'hFFFB};
      vecs[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vecs[3] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
      vecs[4] = '{1'b0, 8'h80, 8'h7F, 16'hC080};
      vecs[5] = '{1'b1, 8'h00, 8'h55, 16'h0000};
      vecs[6] = '{1'b0, 8'hFE, 8'hFD, 16'h0006};

      exp_en[0] = 3'b001; exp_en[1] = 3'b011; exp_en[2] = 3'b000; exp_en[3] = 3'b010;
      for (int i = 4; i < 12; i++) exp_en[i] = 3'b100;
      exp_en[12] = 3'b101; exp_en[13] = 3'b110; exp_en[14] = 3'b000;

      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_m     = '0;
      req_q     = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_enable",  {29'd0, mul_enable}, 32'd0);
      chk("rst_inbus",   {24'd0, mul_inbus}, 32'd0);
      chk("rst_rsp",     {30'd0, rsp_valid}, 32'd0);
      chk("rst_product", {16'd0, rsp_product}, 32'd0);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table, one requester at a time.
      for (int v = 0; v < 7; v++) begin
         req_m     = vecs[v].owner ? {vecs[v].m, 8'h00} : {8'h00, vecs[v].m};
         req_q     = vecs[v].owner ? {vecs[v].q, 8'h00} : {8'h00, vecs[v].q};
         req_valid = vecs[v].owner ? 2'b10 : 2'b01;
         if (v == 0) begin
            rec_arm = 1'b1;
            en_log.delete();
            ib_log.delete();
            #1;
            chk("ready_first", {30'd0, req_ready}, 32'd1);
         end
         wait_acc(1, 2'b11, 20);
         wait_idle(40);
         chk("vec_product", {16'd0, last_prod}, {16'd0, vecs[v].exp});
         chk("vec_owner", {31'd0, last_owner}, {31'd0, vecs[v].owner});
         if (v == 0) begin
            rec_en = 1'b0;
            if (en_log.size() < 15) begin
               flag("enable_seq_len");
            end else begin
               for (int i = 0; i < 15; i++) chk($sformatf("enable_seq[%0d]", i), {29'd0, en_log[i]}, {29'd0, exp_en[i]});
               chk("inbus_init", {24'd0, ib_log[0]}, 32'h11);
               chk("inbus_ldm",  {24'd0, ib_log[1]}, 32'h11);
               chk("inbus_setq", {24'd0, ib_log[2]}, 32'h03);
               chk("inbus_ldq",  {24'd0, ib_log[3]}, 32'h03);
            end
         end
      end
      repeat (5) tick();
      chk("product_hold", {16'd0, rsp_product}, 32'h0006);

      // Simultaneous requests straight after reset.
      do_reset();
      glog.delete();
      req_m     = {8'hFF, 8'h11};
      req_q     = {8'h05, 8'h03};
      req_valid = 2'b11;
      #1;
      chk("ready_both", {30'd0, req_ready}, 32'd1);
      wait_acc(2, 2'b11, 60);
      wait_idle(60);
      if (glog.size() == 2) begin
         chk("both_first",  {31'd0, glog[0].owner}, 32'd0);
         chk("both_second", {31'd0, glog[1].owner}, 32'd1);
         chk("b2b_gap", glog[1].t - glog[0].t, 8 + RUN_CYCLES);
      end else begin
         flag("both_grant_count");
      end

      // Requester 0 held valid throughout while requester 1 joins.
      do_reset();
      glog.delete();
      req_m     = {8'h80, 8'h7F};
      req_q     = {8'h80, 8'h7F};
      req_valid = 2'b01;
      wait_acc(1, 2'b00, 20);
      req_valid = 2'b11;
      wait_acc(2, 2'b10, 60);
      req_valid = 2'b00;
      wait_idle(60);
      if (glog.size() == 3) begin
         chk("alt_0", {31'd0, glog[0].owner}, 32'd0);
         chk("alt_1", {31'd0, glog[1].owner}, 32'd1);
         chk("alt_2", {31'd0, glog[2].owner}, 32'd0);
      end else begin
         flag("alt_grant_count");
      end

      // Reset in the 4th RUN cycle discards the operation.
      req_m     = {8'h00, 8'h11};
      req_q     = {8'h00, 8'h03};
      req_valid = 2'b01;
      wait_acc(1, 2'b01, 20);
      runs = 0;
      for (int i = 0; i < 30 && runs < 4; i++) begin
         @(negedge clk);
         sample();
         if (mul_enable == CMD_RUN) runs++;
         if (runs < 4) begin
            @(posedge clk);
            #1;
         end
      end
      chk("run_seen", runs, 4);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_enable", {29'd0, mul_enable}, 32'd0);
      chk("midrst_busy",   {31'd0, busy}, 32'd0);
      chk("midrst_rsp",    {30'd0, rsp_valid}, 32'd0);
      chk("midrst_inbus",  {24'd0, mul_inbus}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (20) tick();
      req_m     = {8'hFE, 8'h00};
      req_q     = {8'hFD, 8'h00};
      req_valid = 2'b10;
      wait_acc(1, 2'b10, 20);
      wait_idle(40);
      chk("fresh_product", {16'd0, last_prod}, 32'h0006);
      chk("fresh_owner", {31'd0, last_owner}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 8: number of consecutive cycles mul_enable holds the run code.
REQ-002 SHALL have one clock and an asynchronous active-low reset, ports listed next.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester operand-valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 req_m  input  16  multiplicands, {m1,m0}, 8 bits each, two's complement.
REQ-008 req_q  input  16  multipliers, {q1,q0}, 8 bits each, two's complement.
REQ-009 rsp_valid  output  2  one-cycle pulse to the requester owning the result.
REQ-010 rsp_product  output  16  signed product, valid while any rsp_valid bit is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mul_inbus  output  8  operand bus to booth multiplier, registered.
REQ-013 mul_enable  output  3  booth command code, registered.
REQ-014 mul_outbus  input  8  result byte from booth multiplier.

Function
REQ-015 Command codes SHALL be: 000 NOP, 001 INIT, 011 LOAD_M, 010 LOAD_Q, 100 RUN, 101 READ_HI, 110 READ_LO.
REQ-016 FSM states SHALL be IDLE, INIT, LDM, SETQ, LDQ, RUN, RDHI, RDLO, DONE; each is one cycle except RUN (RUN_CYCLES cycles, counted by an internal down-counter).
REQ-017 In IDLE, req_ready SHALL be combinationally high only for the requester granted by the round-robin arbiter among asserted req_valid bits; it SHALL be low in all other states.
REQ-018 Acceptance = req_valid[i] & req_ready[i]; on acceptance the controller SHALL latch m_i, q_i and owner index i, and enter INIT.
REQ-019 Round robin: when both requests are valid, the requester not granted last SHALL win; the last-grant pointer is updated only on acceptance.
REQ-020 Outputs per state: INIT enable=001, inbus=M; LDM enable=011, inbus=M; SETQ enable=000, inbus=Q; LDQ enable=010, inbus=Q; RUN enable=100; RDHI enable=101; RDLO enable=110; DONE and IDLE enable=000; inbus holds its last value outside INIT..LDQ.
REQ-021 mul_outbus SHALL be captured as the product high byte on the clock edge ending RDHI and as the low byte on the edge ending RDLO.
REQ-022 In DONE, rsp_valid[owner] SHALL pulse for exactly one cycle with rsp_product={hi,lo}; the FSM then returns to IDLE. No response backpressure exists.
REQ-023 Latency SHALL be 7+RUN_CYCLES cycles from the acceptance edge to the rsp_valid cycle (15 at default).
REQ-024 rsp_product SHALL hold its last value after DONE until the next DONE.
REQ-025 Requests asserted while busy SHALL wait, with req_ready low; an operation is never preempted.
REQ-026 The next acceptance SHALL be possible in the IDLE cycle immediately following DONE (back-to-back throughput 8+RUN_CYCLES cycles).

Reset
REQ-027 On rst_n low, at any time including mid-operation: state=IDLE, mul_enable=000, mul_inbus=0, rsp_valid=0, rsp_product=0, busy=0, RUN counter=0, last-grant pointer=1 (requester 0 wins first).
REQ-028 An operation interrupted by reset SHALL be discarded with no rsp_valid; the next operation SHALL start from INIT.

Structure
REQ-029 A shared package booth_pkg SHALL hold the command-code constants and the FSM state type.
REQ-030 Two-requester round-robin arbitration SHALL be a sub-module rr_arb2 (req[1:0], pointer in, one-hot grant out).

Verification
REQ-031 Requester 0: M=0x11, Q=0x03 -> mul_enable sequence 001,011,000,010,100x8,101,110,000; rsp_valid=01, rsp_product=0x0033 at cycle 15.
REQ-032 Requester 1: M=0xFF, Q=0x05 -> rsp_valid=10, rsp_product=0xFFFB; M=0x80, Q=0x80 -> 0x4000.
REQ-033 Both req_valid high in the same cycle after reset -> requester 0 served first, requester 1 accepted in the IDLE cycle after DONE, responses in that order.
REQ-034 Requester 0 held valid continuously while requester 1 requests -> grants alternate 0,1,0.
REQ-035 rst_n pulsed low during the 4th RUN cycle -> mul_enable=000 immediately, no rsp_valid; a fresh request then completes correctly in 15 cycles.
REQ-036 Bench SHALL use a behavioural booth model responding to the command codes and SHALL check req_ready is never high outside IDLE.
